// File: rtl/btn_gesture_decoder.sv
// Button gesture decoder: classifies debounced press/release pulses into
// single click, double click and long press one-cycle pulses.
module btn_gesture_decoder #(
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_down,
    input  logic btn_up,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic             click_nx;
    logic             dbl_nx;
    logic             long_nx;
    logic             held_nx;
    logic             down_q;
    logic             up_q;

    // Simultaneous press and release is illegal from the debouncer: drop both.
    assign down_q = btn_down & ~btn_up;
    assign up_q   = btn_up & ~btn_down;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            click      <= 1'b0;
            dbl_click  <= 1'b0;
            long_press <= 1'b0;
            held       <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            click      <= click_nx;
            dbl_click  <= dbl_nx;
            long_press <= long_nx;
            held       <= held_nx;
        end
    end

    always_comb begin
        state_nx = state;
        click_nx = 1'b0;
        dbl_nx   = 1'b0;
        long_nx  = 1'b0;
        timer_nx = timer;

        case (state)
            IDLE: begin
                if (down_q) state_nx = PRESS1;
            end
            PRESS1: begin
                if (up_q) begin
                    state_nx = WAIT2;
                end else if (timer == LONG_LAST) begin
                    state_nx = LONG;
                    long_nx  = 1'b1;
                end
            end
            LONG: begin
                if (up_q) state_nx = IDLE;
            end
            WAIT2: begin
                if (down_q) begin
                    state_nx = PRESS2;
                end else if (timer == GAP_LAST) begin
                    state_nx = IDLE;
                    click_nx = 1'b1;
                end
            end
            PRESS2: begin
                if (up_q) begin
                    state_nx = IDLE;
                    dbl_nx   = 1'b1;
                end else if (timer == LONG_LAST) begin
                    // First tap already completed, so it still counts as a click.
                    state_nx = LONG;
                    click_nx = 1'b1;
                    long_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Timer restarts on every state entry; it is frozen where no timeout applies.
        if (state_nx != state) begin
            timer_nx = '0;
        end else if (state == PRESS1 || state == WAIT2 || state == PRESS2) begin
            timer_nx = timer + CNT_W'(1);
        end

        held_nx = (state_nx == PRESS1) || (state_nx == PRESS2) || (state_nx == LONG);
    end

endmodule
